// File: rtl/sa_cache_pkg.sv
// Shared definitions for the 4-way set-associative cache and its memory-side
// responder: address geometry, data width, FSM state encoding and address
// field helpers.
package sa_cache_pkg;

    localparam int TAG_W    = 18;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 6;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    // Responder FSM encoding; the enum below is bound to these values so the
    // encoding is visible to anything that probes the state register.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_FILL_WAIT = 2'd1;
    localparam logic [1:0] ST_RESPOND   = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        FILL_WAIT = ST_FILL_WAIT,
        RESPOND   = ST_RESPOND
    } resp_state_e;

    // Address layout: {tag, index, offset}.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

    // Byte address to word address; callers truncate to their array depth,
    // so upper bits alias.
    function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return a >> 2;
    endfunction

endpackage

// File: rtl/sa_wb_buffer.sv
// Writeback FIFO of {word_addr, data} with a parallel lookup port that
// returns the newest entry matching a given word address.
module sa_wb_buffer
    import sa_cache_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 10,
    parameter int DW    = DATA_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          drop_o,
    input  logic [AW-1:0] lookup_addr_i,
    output logic          lookup_hit_o,
    output logic [DW-1:0] lookup_data_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             do_pop, do_push;
    logic [PTR_W-1:0] slot;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = (int'(p) + k) % DEPTH;
        return PTR_W'(s);
    endfunction

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full_q || do_pop);
    assign drop_o  = push_i && full_q && !do_pop;

    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = full_q;

    // Pointer and occupancy next-state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = ptr_add(head_q, 1);
        end
        if (do_push) begin
            tail_d = ptr_add(tail_q, 1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d = (count_d == CNT_W'(DEPTH));
    end

    // Pointer, occupancy and registered-full state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Entry storage; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        // NOTE: storage arrays are deliberately not reset; the count makes stale contents invisible.
        if (do_push) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
        end
    end

    // Newest-match lookup: walk oldest to newest so a later hit overrides.
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        slot          = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = ptr_add(head_q, i);
            if ((CNT_W'(i) < count_q) && (addr_q[slot] == lookup_addr_i)) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = data_q[slot];
            end
        end
    end

endmodule

// File: rtl/sa_mem_responder.sv
// Memory-side responder for the set-associative cache: answers fills after a
// fixed latency and absorbs evictions through a forwarding writeback buffer.
module sa_mem_responder
    import sa_cache_pkg::*;
#(
    parameter int    LATENCY   = 4,
    parameter int    MEM_AW    = 10,
    parameter int    WB_DEPTH  = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cache_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              i_evict,
    input  logic [ADDR_W-1:0] i_evict_addr,
    input  logic [DATA_W-1:0] i_evict_data,
    output logic [DATA_W-1:0] o_memory_line,
    output logic              o_memory_response,
    output logic              o_busy,
    output logic              o_wb_full,
    output logic              o_wb_overflow
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              holdoff_q, holdoff_d;
    logic [DATA_W-1:0] line_q, line_d;
    logic              resp_q, resp_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_q [2**MEM_AW];

    logic [MEM_AW-1:0] miss_word, evict_word;
    logic              wb_pop, wb_empty, wb_full, wb_drop, wb_hit;
    logic [MEM_AW-1:0] wb_head_addr;
    logic [DATA_W-1:0] wb_head_data, wb_hit_data;
    logic [DATA_W-1:0] fill_data;

    assign miss_word  = MEM_AW'(word_of(i_miss_addr));
    assign evict_word = MEM_AW'(word_of(i_evict_addr));

    // The array port belongs to the fill outside IDLE, so drains wait for IDLE.
    assign wb_pop = (state_q == IDLE) && !wb_empty;

    sa_wb_buffer #(
        .DEPTH (WB_DEPTH),
        .AW    (MEM_AW),
        .DW    (DATA_W)
    ) u_wb (
        .clk           (clk),
        .rst           (rst),
        .push_i        (i_evict),
        .push_addr_i   (evict_word),
        .push_data_i   (i_evict_data),
        .pop_i         (wb_pop),
        .head_addr_o   (wb_head_addr),
        .head_data_o   (wb_head_data),
        .empty_o       (wb_empty),
        .full_o        (wb_full),
        .drop_o        (wb_drop),
        .lookup_addr_i (addr_q),
        .lookup_hit_o  (wb_hit),
        .lookup_data_o (wb_hit_data)
    );

    // Fill data priority: same-cycle evict > newest buffered writeback > array.
    always_comb begin
        fill_data = mem_q[addr_q];
        if (i_evict && (evict_word == addr_q)) begin
            fill_data = i_evict_data;
        end else if (wb_hit) begin
            fill_data = wb_hit_data;
        end
    end

    // FSM next-state, latency counter and fill capture.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        line_d    = line_q;
        holdoff_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_cache_miss && !holdoff_q) begin
                    state_d = FILL_WAIT;
                    cnt_d   = CNT_W'(LATENCY);
                    addr_d  = miss_word;
                end
            end
            FILL_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    line_d  = fill_data;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                // A miss line still high from this fill must not retrigger.
                state_d   = IDLE;
                holdoff_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        resp_d = (state_d == RESPOND);
        busy_d = (state_d != IDLE);
        ovf_d  = ovf_q || wb_drop;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            holdoff_q <= 1'b0;
            line_q    <= '0;
            resp_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            holdoff_q <= holdoff_d;
            line_q    <= line_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    // Backing array write port, fed by writeback drains.
    always_ff @(posedge clk) begin
        if (wb_pop) begin
            mem_q[wb_head_addr] <= wb_head_data;
        end
    end

    assign o_memory_line     = line_q;
    assign o_memory_response = resp_q;
    assign o_busy            = busy_q;
    assign o_wb_full         = wb_full;
    assign o_wb_overflow     = ovf_q;

endmodule

// File: tb/tb_sa_mem_responder.sv
// Scoreboard bench for sa_mem_responder: directed scenarios followed by
// randomized misses/evicts, checked against a transaction-level memory model.
module tb_sa_mem_responder;

    localparam int LATENCY  = 4;
    localparam int MEM_AW   = 10;
    localparam int WB_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_cache_miss = 1'b0;
    logic [31:0] i_miss_addr = '0;
    logic        i_evict = 1'b0;
    logic [31:0] i_evict_addr = '0;
    logic [31:0] i_evict_data = '0;
    logic [31:0] o_memory_line;
    logic        o_memory_response;
    logic        o_busy;
    logic        o_wb_full;
    logic        o_wb_overflow;

    always #5 clk = ~clk;

    sa_mem_responder #(
        .LATENCY   (LATENCY),
        .MEM_AW    (MEM_AW),
        .WB_DEPTH  (WB_DEPTH),
        .INIT_FILE ("")
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_cache_miss      (i_cache_miss),
        .i_miss_addr       (i_miss_addr),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_busy            (o_busy),
        .o_wb_full         (o_wb_full),
        .o_wb_overflow     (o_wb_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          addr;
        logic [31:0] data;
    } wb_t;

    logic [31:0] m_mem [int];   // committed array contents by word address
    wb_t         m_buf [$];     // writebacks not yet in the array, oldest first
    int          m_fill_left;   // edges until the fill data is registered
    int          m_fill_addr;
    bit          m_resp;
    bit          m_holdoff;
    bit          m_ovf;
    logic [31:0] exp_line;
    bit          exp_resp, exp_busy, exp_full, exp_ovf;
    logic [31:0] sb [$];        // expected data of each pending response

    function automatic int word(input logic [31:0] a);
        return int'((a >> 2) & 32'((1 << MEM_AW) - 1));
    endfunction

    task automatic model_reset();
        m_buf.delete();
        sb.delete();
        m_fill_left = 0;
        m_resp      = 1'b0;
        m_holdoff   = 1'b0;
        m_ovf       = 1'b0;
        exp_line    = '0;
        exp_resp    = 1'b0;
        exp_busy    = 1'b0;
        exp_full    = 1'b0;
        exp_ovf     = 1'b0;
    endtask

    task automatic model_step();
        bit          idle;
        logic [31:0] sel;
        idle = (m_fill_left == 0) && !m_resp;
        sel  = '0;
        // The most recent write to the fill address wins.
        if (m_fill_left == 1) begin
            sel = m_mem.exists(m_fill_addr) ? m_mem[m_fill_addr] : 32'h0;
            foreach (m_buf[i]) begin
                if (m_buf[i].addr == m_fill_addr) sel = m_buf[i].data;
            end
            if (i_evict && word(i_evict_addr) == m_fill_addr) sel = i_evict_data;
        end
        if (idle && m_buf.size() > 0) begin
            wb_t h;
            h = m_buf.pop_front();
            m_mem[h.addr] = h.data;
        end
        if (i_evict) begin
            if (m_buf.size() < WB_DEPTH) begin
                wb_t e;
                e.addr = word(i_evict_addr);
                e.data = i_evict_data;
                m_buf.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (m_resp) begin
            m_resp    = 1'b0;
            m_holdoff = 1'b1;
        end else if (m_fill_left > 0) begin
            m_fill_left--;
            if (m_fill_left == 0) begin
                m_resp   = 1'b1;
                exp_line = sel;
                sb.push_back(sel);
            end
        end else if (m_holdoff) begin
            m_holdoff = 1'b0;
        end else if (i_cache_miss) begin
            m_fill_left = LATENCY;
            m_fill_addr = word(i_miss_addr);
        end
        exp_resp = m_resp;
        exp_busy = (m_fill_left > 0) || m_resp;
        exp_full = (m_buf.size() == WB_DEPTH);
        exp_ovf  = m_ovf;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_on) begin
            check("busy", {31'b0, o_busy}, {31'b0, exp_busy});
            check("wb_full", {31'b0, o_wb_full}, {31'b0, exp_full});
            check("wb_overflow", {31'b0, o_wb_overflow}, {31'b0, exp_ovf});
            check("response", {31'b0, o_memory_response}, {31'b0, exp_resp});
            check("line_hold", o_memory_line, exp_line);
            if (o_memory_response) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_response: got line %08h, no fill pending at %0t",
                             o_memory_line, $time);
                end else begin
                    check("fill_data", o_memory_line, sb.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change at a falling edge and are sampled at the next rising edge.
    task automatic cyc(input bit miss, input logic [31:0] maddr,
                       input bit ev, input logic [31:0] eaddr, input logic [31:0] edata);
        i_cache_miss = miss;
        i_miss_addr  = maddr;
        i_evict      = ev;
        i_evict_addr = eaddr;
        i_evict_data = edata;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        i_cache_miss = 1'b0;
        i_evict      = 1'b0;
        #2 rst = 1'b1;
        repeat (n) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Hold a miss through accept, response and holdoff; evict to ea on cycles
    // e_from .. e_from+e_n-1 (cycle 1 is the accept edge).
    task automatic miss_ev(input logic [31:0] a, input int e_from, input int e_n,
                           input logic [31:0] ea, input logic [31:0] ed [3]);
        for (int k = 1; k <= LATENCY + 3; k++) begin
            if (k >= e_from && k < e_from + e_n) cyc(1'b1, a, 1'b1, ea, ed[k - e_from]);
            else                                 cyc(1'b1, a, 1'b0, 32'h0, 32'h0);
        end
    endtask

    int pool [8] = '{'h010, 'h040, 'h080, 'h0C0, 'h140, 'h001, 'h3FF, 'h2AA};

    function automatic logic [31:0] rand_addr();
        int w;
        w = pool[$urandom_range(0, 7)];
        return ($urandom() & 32'hFFFF_F003) | (32'(w) << 2);
    endfunction

    logic [31:0] none [3] = '{32'h0, 32'h0, 32'h0};

    initial begin
        #1 rst = 1'b1;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // Idle with no miss: nothing may respond.
        idle(10);

        // Give every address the bench touches a known array value.
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1, 32'(pool[i]) << 2, 32'h1000_0000 + 32'(i));
        idle(4);

        // Drained writeback is returned; miss held past holdoff gives one pulse.
        cyc(1'b0, 32'h0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        idle(2);
        miss_ev(32'h0000_0040, 0, 0, 32'h0, none);
        idle(3);

        // Evict during FILL_WAIT is forwarded, then drained into the array.
        miss_ev(32'h0000_0100, 3, 1, 32'h0000_0100, '{32'hA5A5_0001, 32'h0, 32'h0});
        idle(3);
        miss_ev(32'h0000_0100, 0, 0, 32'h0, none);
        idle(3);

        // Newest buffered entry wins; same-cycle evict in the counter==1 cycle wins.
        miss_ev(32'h0000_0200, 2, 2, 32'h0000_0200, '{32'h1, 32'h2, 32'h0});
        idle(3);
        miss_ev(32'h0000_0200, LATENCY + 1, 1, 32'h0000_0200, '{32'h3, 32'h0, 32'h0});
        idle(3);

        // Overflow: third evict on a full buffer during a fill is dropped.
        miss_ev(32'h0000_0500, 2, 3, 32'h0000_0300, '{32'h11, 32'h22, 32'h33});
        idle(3);
        miss_ev(32'h0000_0300, 0, 0, 32'h0, none);
        idle(3);

        // Reset mid-fill with a buffered writeback: no pulse, writeback lost.
        cyc(1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 32'h0000_0500, 1'b1, 32'h0000_0500, 32'hBAD0_0006);
        cyc(1'b1, 32'h0000_0500, 1'b0, 32'h0, 32'h0);
        do_reset(2);
        idle(2);
        miss_ev(32'h0000_0500, 0, 0, 32'h0, none);
        idle(3);

        // Randomized traffic with aliased upper address bits.
        for (int it = 0; it < 80; it++) begin
            int gap;
            logic [31:0] a;
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0, 32'h0, ($urandom_range(0, 2) == 0), rand_addr(), $urandom());
            end
            a = rand_addr();
            for (int k = 0; k < LATENCY + 3; k++) begin
                cyc(1'b1, a, ($urandom_range(0, 2) == 0), rand_addr(), $urandom());
            end
        end
        idle(6);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
